// File: rtl/haze_recover_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : haze_recover_pipe_pkg
//  Description : Shared widths, defaults and the output clamp for the
//                scene-radiance recovery pipeline.
//  Revision    : 1.0 - initial release
// ============================================================================
package haze_recover_pipe_pkg;

  localparam int PIX_W     = 8;            // pixel / t / A width
  localparam int RECIP_W   = 16;           // Q8.8 reciprocal width
  localparam int FRAC_W    = 8;            // fractional bits of reciprocal
  localparam int T_MIN_DEF = 26;           // ~0.1 on the 8-bit t scale
  localparam int NUM_CH    = 3;            // R, G, B
  localparam int DIFF_W    = PIX_W + 1;    // signed I - A
  localparam int PROD_W    = 26;           // signed d * R
  localparam int SUM_W     = 14;           // signed A + (p >>> FRAC_W)

  localparam logic signed [SUM_W-1:0] PIX_MAX = SUM_W'((1 << PIX_W) - 1);

  // Saturate a signed intermediate into the unsigned pixel range.
  function automatic logic [PIX_W-1:0] clamp_u8(input logic signed [SUM_W-1:0] v);
    logic [PIX_W-1:0] res;
    if (v[SUM_W-1]) begin
      res = '0;
    end else if (v > PIX_MAX) begin
      res = '1;
    end else begin
      res = v[PIX_W-1:0];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/haze_recover_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : haze_recover_pipe_if
//  Description : Input and output valid/ready streams of the recovery stage.
//                master = surrounding datapath, slave = recovery stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface haze_recover_pipe_if;
  import haze_recover_pipe_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_r;
  logic [PIX_W-1:0] in_g;
  logic [PIX_W-1:0] in_b;
  logic [PIX_W-1:0] in_t;
  logic [PIX_W-1:0] atm_r;
  logic [PIX_W-1:0] atm_g;
  logic [PIX_W-1:0] atm_b;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_r;
  logic [PIX_W-1:0] out_g;
  logic [PIX_W-1:0] out_b;

  modport master (
    output in_valid, in_r, in_g, in_b, in_t, atm_r, atm_g, atm_b, out_ready,
    input  in_ready, out_valid, out_r, out_g, out_b
  );

  modport slave (
    input  in_valid, in_r, in_g, in_b, in_t, atm_r, atm_g, atm_b, out_ready,
    output in_ready, out_valid, out_r, out_g, out_b
  );

endinterface
`default_nettype wire

// File: rtl/haze_recover_pipe_rom.sv
`default_nettype none
// ============================================================================
//  Module      : recip_q8_rom
//  Description : 256 x 16 reciprocal table, entry i = floor(65535 / i),
//                entry 0 = 65535. Registered read with enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module recip_q8_rom
  import haze_recover_pipe_pkg::*;
(
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               en,
  input  wire logic [PIX_W-1:0]   addr,
  output logic      [RECIP_W-1:0] data
);

  localparam int DEPTH   = 1 << PIX_W;
  localparam int NUMER   = (1 << RECIP_W) - 1;

  logic [RECIP_W-1:0] w_table [DEPTH];

  // Table contents are elaboration-time constants; index 0 divides by 1.
  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam int DIV = (i == 0) ? 1 : i;
    localparam int VAL = NUMER / DIV;
    assign w_table[i] = RECIP_W'(VAL);
  end

  // Synchronous read, advancing with the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (en) begin
      data <= w_table[addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/haze_recover_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : haze_recover_pipe
//  Description : Scene-radiance recovery J = A + (I - A) * R(t) >> 8 per
//                channel, R = Q8.8 reciprocal of clamped t. Four stages,
//                whole-pipe stall on output backpressure.
//  Revision    : 1.0 - initial release
// ============================================================================
module haze_recover_pipe
  import haze_recover_pipe_pkg::*;
#(
  parameter int T_MIN = T_MIN_DEF
)
(
  input wire logic           clk,
  input wire logic           rst,
  haze_recover_pipe_if.slave bus
);

  localparam logic [PIX_W-1:0] T_MIN_V = PIX_W'(T_MIN);

  logic               w_adv;
  logic [4:1]         r_vld;
  logic [PIX_W-1:0]   r_tc;
  logic [RECIP_W-1:0] w_recip;
  logic [PIX_W-1:0]   w_pix [NUM_CH];
  logic [PIX_W-1:0]   w_atm [NUM_CH];
  logic [PIX_W-1:0]   w_out [NUM_CH];

  // The whole pipe moves as one; it only halts when the output is blocked.
  assign w_adv         = !r_vld[4] || bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_vld[4];

  assign w_pix[0] = bus.in_r;
  assign w_pix[1] = bus.in_g;
  assign w_pix[2] = bus.in_b;
  assign w_atm[0] = bus.atm_r;
  assign w_atm[1] = bus.atm_g;
  assign w_atm[2] = bus.atm_b;

  assign bus.out_r = w_out[0];
  assign bus.out_g = w_out[1];
  assign bus.out_b = w_out[2];

  // Valid shift register; empty slots travel as bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
    end else if (w_adv) begin
      r_vld <= {r_vld[3:1], bus.in_valid};
    end
  end

  // Stage 1: clamp t so the reciprocal stays bounded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tc <= '0;
    end else if (w_adv) begin
      r_tc <= (bus.in_t < T_MIN_V) ? T_MIN_V : bus.in_t;
    end
  end

  // Stage 2: one reciprocal lookup shared by all channels.
  recip_q8_rom u_rom (
    .clk  (clk),
    .rst  (rst),
    .en   (w_adv),
    .addr (r_tc),
    .data (w_recip)
  );

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic signed [DIFF_W-1:0] r_d1;
    logic signed [DIFF_W-1:0] r_d2;
    logic signed [PROD_W-1:0] r_p3;
    logic        [PIX_W-1:0]  r_a1;
    logic        [PIX_W-1:0]  r_a2;
    logic        [PIX_W-1:0]  r_a3;
    logic        [PIX_W-1:0]  r_out;
    logic signed [SUM_W-1:0]  w_sum;

    // Arithmetic shift floors the scaled difference; magnitude fits SUM_W.
    assign w_sum = SUM_W'(r_p3 >>> FRAC_W) + $signed(SUM_W'(r_a3));

    // Stages 1..4 of this channel: difference, carry, multiply, add+clamp.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_d1  <= '0;
        r_d2  <= '0;
        r_p3  <= '0;
        r_a1  <= '0;
        r_a2  <= '0;
        r_a3  <= '0;
        r_out <= '0;
      end else if (w_adv) begin
        r_d1  <= $signed({1'b0, w_pix[ch]}) - $signed({1'b0, w_atm[ch]});
        r_a1  <= w_atm[ch];
        r_d2  <= r_d1;
        r_a2  <= r_a1;
        r_p3  <= PROD_W'(r_d2) * $signed({{(PROD_W-RECIP_W){1'b0}}, w_recip});
        r_a3  <= r_a2;
        r_out <= clamp_u8(w_sum);
      end
    end

    assign w_out[ch] = r_out;
  end

endmodule
`default_nettype wire

// File: tb/tb_haze_recover_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_haze_recover_pipe
//  Description : Self-checking bench for haze_recover_pipe: directed corner
//                beats, randomized backpressured stream, mid-flight reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_haze_recover_pipe;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  haze_recover_pipe_if bus ();

  haze_recover_pipe #(.T_MIN(26)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // J = clamp(A + floor((I - A) * floor(65535 / max(t, 26)) / 256))
  function automatic int ref_j(input int i, input int a, input int t);
    int tc, r, p, q, s;
    tc = (t < 26) ? 26 : t;
    r  = 65535 / tc;
    p  = (i - a) * r;
    q  = (p >= 0) ? (p / 256) : -((-p + 255) / 256);
    s  = a + q;
    if (s < 0) s = 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  function automatic logic [31:0] out_pix();
    return {8'h00, bus.out_r, bus.out_g, bus.out_b};
  endfunction

  task automatic set_beat(input int ir, input int ig, input int ib,
                          input int ar, input int ag, input int ab, input int t);
    bus.in_r  = 8'(ir);
    bus.in_g  = 8'(ig);
    bus.in_b  = 8'(ib);
    bus.atm_r = 8'(ar);
    bus.atm_g = 8'(ag);
    bus.atm_b = 8'(ab);
    bus.in_t  = 8'(t);
  endtask

  // One isolated beat; output must appear exactly four edges after acceptance.
  task automatic directed(input string tag, input int i, input int a, input int t, input int j_exp);
    @(posedge clk); #1;
    set_beat(i, i, i, a, a, a, t);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_early"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_r"}, 32'(bus.out_r), 32'(j_exp));
    check({tag, "_g"}, 32'(bus.out_g), 32'(ref_j(i, a, t)));
    check({tag, "_b"}, 32'(bus.out_b), 32'(ref_j(i, a, t)));
  endtask

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] held;
    logic [31:0] want;
    logic        acc, fire, stall_prev, need_new;
    int          sent, got, cyc, stale;
    int          ir, ig, ib, ar, ag, ab, t;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_beat(0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pix", out_pix(), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);
    check("rel_out_valid", 32'(bus.out_valid), 32'd0);

    // Directed corner beats
    directed("mid_t", 200, 220, 128, 180);
    directed("clamp_low", 0, 200, 0, 0);
    directed("clamp_high", 255, 100, 64, 255);
    directed("t_max", 50, 200, 255, 49);
    directed("t_below_min", 90, 30, 10, ref_j(90, 30, 26));

    // Randomized back-to-back stream with random backpressure
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    exp_q.delete();
    sent = 0; got = 0; cyc = 0;
    stall_prev = 1'b0;
    need_new   = 1'b1;
    held       = '0;
    while ((got < 16) && (cyc < 400)) begin
      @(posedge clk); #1;
      cyc++;
      if (stall_prev) begin
        check("stall_valid", 32'(bus.out_valid), 32'd1);
        check("stall_hold", out_pix(), held);
      end
      if (sent < 16) begin
        if (need_new) begin
          ir = $urandom_range(0, 255); ig = $urandom_range(0, 255); ib = $urandom_range(0, 255);
          ar = $urandom_range(0, 255); ag = $urandom_range(0, 255); ab = $urandom_range(0, 255);
          t  = $urandom_range(0, 255);
          set_beat(ir, ig, ib, ar, ag, ab, t);
          need_new = 1'b0;
        end
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      bus.out_ready = 1'($urandom_range(0, 1));
      #1;
      acc        = bus.in_valid && bus.in_ready;
      fire       = bus.out_valid && bus.out_ready;
      stall_prev = bus.out_valid && !bus.out_ready;
      held       = out_pix();
      if (acc) begin
        exp_q.push_back({8'h00, 8'(ref_j(ir, ar, t)), 8'(ref_j(ig, ag, t)), 8'(ref_j(ib, ab, t))});
        sent++;
        need_new = 1'b1;
      end
      if (fire) begin
        check("stream_has_expect", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          check("stream_data", out_pix(), want);
        end
        got++;
      end
    end
    check("stream_sent", 32'(sent), 32'd16);
    check("stream_got", 32'(got), 32'd16);
    check("stream_leftover", 32'(exp_q.size()), 32'd0);

    // Reset with one beat stalled at the output and three behind it
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_beat(10 * k, 20 * k, 30 * k, 128, 128, 128, 100);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(bus.out_valid), 32'd0);
    check("rst_async_pix", out_pix(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) stale++;
    end
    check("rst_no_stale", 32'(stale), 32'd0);
    directed("post_rst", 200, 220, 128, 180);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
